lock_ctrl_multi: RTL
====================

LOCK_CTRL_MULTI -- requirements
Module: lock_ctrl_multi

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter CLK_FREQ_HZ, 1000: clock cycles per second.
REQ-003 Parameter PIN_DIGITS, 4: digits per PIN, legal range 2..8.
REQ-004 Parameter NUM_PINS, 4: PIN table entries, legal range 1..8.
REQ-005 Parameter MAX_FAILS, 3: consecutive failures that trigger lockout.
REQ-006 Parameter LOCK_BASE_S, 10: base lockout duration in seconds.
REQ-007 Parameter DIGIT_TIMEOUT_S, 5: idle time in seconds before a partial entry is discarded.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous active-low reset.
REQ-010 sensor_de_contato  in  1  1 = door closed.
REQ-011 botao_interno  in  1  internal exit button, level.
REQ-012 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-013 key_code  in  4  0-9 = digit, 0xE = clear, others ignored.
REQ-014 cfg_we  in  1  PIN table write strobe.
REQ-015 cfg_idx  in  clog2(NUM_PINS), min 1  table entry index.
REQ-016 cfg_pin  in  4*PIN_DIGITS  BCD PIN, first digit in MS nibble; cfg_en  in  1  entry valid.
REQ-017 relock_time, bip_time  in  8 each  seconds; bip_status  in  1  door-open alarm enable.
REQ-018 tranca  out  1  1 = locked; bip  out  1  alarm.
REQ-019 bcd_out  out  4*PIN_DIGITS  display nibbles; bcd_enable  out  1.
REQ-020 locked_out  out  1  lockout active; match_idx  out  clog2(NUM_PINS), min 1  last matching entry.

Function
REQ-021 States SHALL be IDLE, CHECK, OPEN_CLOSED (unlocked, door shut), OPEN_AJAR (unlocked, door open), LOCKOUT.
REQ-022 In IDLE, a digit SHALL shift into the LS nibble of the entry buffer, older digits moving left, and increment the digit count; 0xE SHALL clear the buffer and count.
REQ-023 When the count reaches PIN_DIGITS the FSM SHALL enter CHECK on the next edge; key_valid outside IDLE SHALL be ignored.
REQ-024 With count>0 and no key_valid for DIGIT_TIMEOUT_S*CLK_FREQ_HZ cycles, the buffer SHALL clear without counting a failure.
REQ-025 In IDLE, bcd_enable=1; bcd_out SHALL show entered digits right-aligned, with unfilled nibbles 0xF. In LOCKOUT, bcd_out SHALL be all 0xC and bcd_enable=1. In other states, bcd_enable=0.
REQ-026 CHECK SHALL last one cycle and compare the buffer against all entries with cfg_en=1 in parallel. On a match, the lowest index wins and goes to match_idx.
REQ-027 On a match: tranca<=0, fail count<=0, escalation level<=0, enter OPEN_CLOSED with the relock counter at 0.
REQ-028 On a mismatch: fail count+1. If it reaches MAX_FAILS, enter LOCKOUT with locked_out=1. Otherwise return to IDLE with the buffer cleared.
REQ-029 LOCKOUT SHALL last (LOCK_BASE_S*CLK_FREQ_HZ)<<level cycles. On expiry: fail count<=0, locked_out<=0, go to IDLE, and level is retained.
REQ-030 A rising edge of botao_interno in IDLE or LOCKOUT SHALL unlock and enter OPEN_CLOSED. From LOCKOUT this also clears fail count and locked_out, and leaves level unchanged.
REQ-031 In OPEN_CLOSED, the relock counter SHALL increment each cycle. At relock_time*CLK_FREQ_HZ, or on a botao_interno rising edge: tranca<=1, go to IDLE with the buffer cleared. relock_time=0 SHALL relock on the next edge.
REQ-032 sensor_de_contato=0 in OPEN_CLOSED SHALL enter OPEN_AJAR and zero both counters. Door open takes priority over a simultaneous relock.
REQ-033 In OPEN_AJAR, the bip counter SHALL saturate at bip_time*CLK_FREQ_HZ. bip=1 while saturated and bip_status=1. Door close SHALL force bip=0 and enter OPEN_CLOSED with the relock counter at 0.
REQ-034 cfg_we SHALL write the entry on that edge in any state. A write coincident with CHECK SHALL NOT affect that comparison.
REQ-035 Counters SHALL be wide enough for max((LOCK_BASE_S*CLK_FREQ_HZ)<<4, 255*CLK_FREQ_HZ) without wrap.

Reset
REQ-036 On rst=0: state IDLE, tranca=1, bip=0, bcd_out all 0xF, bcd_enable=0, locked_out=0, match_idx=0, all counters and level 0.
REQ-037 Reset SHALL set the PIN table to entry 0 = all zeros with cfg_en=1, and all other entries invalid. Reset mid-unlock SHALL relock immediately.

Configuration
REQ-038 With ESCALATING_LOCKOUT_EN defined, each entry into LOCKOUT SHALL increment level after computing the duration, saturating at 4. Without it, level SHALL stay 0, giving a fixed lockout.

Verification
REQ-039 Reset, keys 0,0,0,0 -> CHECK one cycle later, tranca=0, match_idx=0.
REQ-040 Three wrong PINs (1,1,1,1) -> locked_out=1, bcd_out all 0xC for 10000 cycles; with macro, next lockout lasts 20000 cycles.
REQ-041 Unlock, door stays closed, relock_time=5 -> tranca=1 after exactly 5000 cycles.
REQ-042 Unlock, door open, bip_time=2, bip_status=1 -> bip=1 from cycle 2000; door closes -> bip=0 on the next edge.
REQ-043 Keys 1,2 then 5000 idle cycles -> buffer cleared, fail count unchanged; cfg write of entry 3 = 9,8,7,6 -> that PIN unlocks with match_idx=3.

Source files
------------

// File: rtl/lock_ctrl_multi.sv
// lock_ctrl_multi: keypad door lock with a multi-entry PIN table, digit
// timeout, failed-attempt lockout, timed relock and door-ajar alarm.
// Optional feature macro: ESCALATING_LOCKOUT_EN -- when defined, each entry
// into LOCKOUT doubles the following lockout duration (level saturates at 4);
// when undefined, the lockout duration is fixed.
// Key interface: key_valid is a one-cycle strobe qualifying key_code. There is
// no back-pressure; strobes arriving outside IDLE are dropped.
// botao_interno is assumed synchronous to clk (edge-detected, not synchronised).
module lock_ctrl_multi #(
  parameter int CLK_FREQ_HZ     = 1000,
  parameter int PIN_DIGITS      = 4,
  parameter int NUM_PINS        = 4,
  parameter int MAX_FAILS       = 3,
  parameter int LOCK_BASE_S     = 10,
  parameter int DIGIT_TIMEOUT_S = 5,
  localparam int IDX_W          = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  localparam int PIN_W          = 4 * PIN_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_de_contato,
  input  logic             botao_interno,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic             cfg_en,
  input  logic [7:0]       relock_time,
  input  logic [7:0]       bip_time,
  input  logic             bip_status,
  output logic             tranca,
  output logic             bip,
  output logic [PIN_W-1:0] bcd_out,
  output logic             bcd_enable,
  output logic             locked_out,
  output logic [IDX_W-1:0] match_idx,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CHECK       = 3'd1,
    S_OPEN_CLOSED = 3'd2,
    S_OPEN_AJAR   = 3'd3,
    S_LOCKOUT     = 3'd4
  } state_t;

  // One shared timer serves the idle, relock, bip and lockout counts: those
  // uses belong to mutually exclusive states and the timer is zeroed on every
  // transition between them. It must hold the longest of those counts.
  localparam longint unsigned CLK_L      = longint'(CLK_FREQ_HZ);
  localparam longint unsigned LOCK_CYC   = longint'(LOCK_BASE_S) * CLK_L;
  localparam longint unsigned LOCK_MAX   = LOCK_CYC << 4;
  localparam longint unsigned RELOCK_MAX = 255 * CLK_L;
  localparam longint unsigned TO_CYC     = longint'(DIGIT_TIMEOUT_S) * CLK_L;
  localparam longint unsigned MAX_A      = (LOCK_MAX > RELOCK_MAX) ? LOCK_MAX : RELOCK_MAX;
  localparam longint unsigned MAX_CNT    = (MAX_A > TO_CYC) ? MAX_A : TO_CYC;
  localparam int CNT_W  = $clog2(MAX_CNT + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int DCNT_W = $clog2(PIN_DIGITS + 1);

  state_t              state_q, state_d;
  logic [PIN_W-1:0]    buf_q, buf_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    tmr_q, tmr_d;
  logic [FAIL_W-1:0]   fails_q, fails_d;
  logic [2:0]          lvl_q, lvl_d;
  logic [2:0]          shift_q, shift_d;
  logic [IDX_W-1:0]    midx_q, midx_d;
  logic                btn_q;
  logic [PIN_W-1:0]    bcd_q, bcd_d;
  logic                bcd_en_q, bcd_en_d;
  logic [PIN_W-1:0]    pin_q [NUM_PINS];
  logic [NUM_PINS-1:0] en_q;

  logic                btn_rise;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [CNT_W:0]      tmr_nx, relock_lim, idle_lim, lock_lim;
  logic [CNT_W-1:0]    bip_lim;
  logic [FAIL_W-1:0]   fails_nx;

  assign btn_rise   = botao_interno & ~btn_q;
  assign tmr_nx     = {1'b0, tmr_q} + (CNT_W+1)'(1);
  assign relock_lim = {1'b0, CNT_W'(relock_time) * CNT_W'(CLK_FREQ_HZ)};
  assign bip_lim    = CNT_W'(bip_time) * CNT_W'(CLK_FREQ_HZ);
  assign idle_lim   = (CNT_W+1)'(TO_CYC);
  assign lock_lim   = {1'b0, CNT_W'(LOCK_CYC) << shift_q};
  assign fails_nx   = fails_q + FAIL_W'(1);

  // Parallel compare of the entry buffer against every enabled entry; the
  // downward scan leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (en_q[i] && (pin_q[i] == buf_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Next-state and datapath updates for the lock FSM.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    fails_d = fails_q;
    lvl_d   = lvl_q;
    shift_d = shift_q;
    midx_d  = midx_q;
    case (state_q)
      S_IDLE: begin
        if (btn_rise) begin
          state_d = S_OPEN_CLOSED;
          tmr_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key_valid) begin
          tmr_d = '0;
          if (key_code <= 4'd9) begin
            buf_d = {buf_q[PIN_W-5:0], key_code};
            cnt_d = cnt_q + DCNT_W'(1);
            if (cnt_d == DCNT_W'(PIN_DIGITS)) state_d = S_CHECK;
          end else if (key_code == 4'hE) begin
            buf_d = '0;
            cnt_d = '0;
          end
        end else if (cnt_q != '0) begin
          // Abandoned partial entry: drop it silently, no failure counted.
          if (tmr_nx >= idle_lim) begin
            buf_d = '0;
            cnt_d = '0;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_nx[CNT_W-1:0];
          end
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (hit) begin
          midx_d  = hit_idx;
          fails_d = '0;
          lvl_d   = '0;
          state_d = S_OPEN_CLOSED;
        end else if (fails_nx >= FAIL_W'(MAX_FAILS)) begin
          fails_d = fails_nx;
          shift_d = lvl_q;
`ifdef ESCALATING_LOCKOUT_EN
          lvl_d   = (lvl_q < 3'd4) ? lvl_q + 3'd1 : lvl_q;
`else
          lvl_d   = lvl_q;
`endif
          state_d = S_LOCKOUT;
        end else begin
          fails_d = fails_nx;
          state_d = S_IDLE;
        end
      end
      S_OPEN_CLOSED: begin
        // An opening door wins over a relock in the same cycle.
        if (!sensor_de_contato) begin
          state_d = S_OPEN_AJAR;
          tmr_d   = '0;
        end else if (btn_rise || (tmr_nx >= relock_lim)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_nx[CNT_W-1:0];
        end
      end
      S_OPEN_AJAR: begin
        if (sensor_de_contato) begin
          state_d = S_OPEN_CLOSED;
          tmr_d   = '0;
        end else if (tmr_q < bip_lim) begin
          tmr_d = tmr_nx[CNT_W-1:0];
        end
      end
      S_LOCKOUT: begin
        if (btn_rise) begin
          state_d = S_OPEN_CLOSED;
          fails_d = '0;
          tmr_d   = '0;
        end else if (tmr_nx >= lock_lim) begin
          state_d = S_IDLE;
          fails_d = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_nx[CNT_W-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Display image derived from next-state values so it lines up with state_q.
  always_comb begin
    bcd_d    = '1;
    bcd_en_d = 1'b0;
    if (state_d == S_IDLE) begin
      bcd_en_d = 1'b1;
      for (int i = 0; i < PIN_DIGITS; i++) begin
        if (DCNT_W'(i) < cnt_d) bcd_d[4*i +: 4] = buf_d[4*i +: 4];
      end
    end else if (state_d == S_LOCKOUT) begin
      bcd_en_d = 1'b1;
      bcd_d    = {PIN_DIGITS{4'hC}};
    end
  end

  // FSM state, counters and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      fails_q  <= '0;
      lvl_q    <= '0;
      shift_q  <= '0;
      midx_q   <= '0;
      btn_q    <= 1'b0;
      bcd_q    <= '1;
      bcd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      fails_q  <= fails_d;
      lvl_q    <= lvl_d;
      shift_q  <= shift_d;
      midx_q   <= midx_d;
      btn_q    <= botao_interno;
      bcd_q    <= bcd_d;
      bcd_en_q <= bcd_en_d;
    end
  end

  // PIN table: entry 0 = all zeros enabled after reset, writable in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PINS; i++) pin_q[i] <= '0;
      en_q <= NUM_PINS'(1);
    end else if (cfg_we && (int'(cfg_idx) < NUM_PINS)) begin
      pin_q[cfg_idx] <= cfg_pin;
      en_q[cfg_idx]  <= cfg_en;
    end
  end

  assign tranca      = !((state_q == S_OPEN_CLOSED) || (state_q == S_OPEN_AJAR));
  assign locked_out  = (state_q == S_LOCKOUT);
  assign bip         = (state_q == S_OPEN_AJAR) && (tmr_q >= bip_lim) && bip_status;
  assign bcd_out     = bcd_q;
  assign bcd_enable  = bcd_en_q;
  assign match_idx   = midx_q;
  assign dbg_state_o = state_q;

endmodule
